// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: pin synchronisers, clock deglitch filter, 11-bit frame
// checker, E0/F0 prefix merging and a small scan-code FIFO with valid/ready output.
module ps2_scancode_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_AW        = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ps2_clock,
  input  logic               ps2_data,
  output logic [7:0]         code_out,
  output logic               code_break,
  output logic               code_extended,
  output logic               code_valid,
  input  logic               code_ready,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               parity_error,
  output logic               frame_error,
  output logic               overflow
);

  localparam int FLT_W = $clog2(FILTER_LEN) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers: bit 0 = ps2_clock, bit 1 = ps2_data. Idle bus is high.
  // ---------------------------------------------------------------------------
  logic [1:0] pin_raw;
  logic [1:0] pin_sync;

  assign pin_raw = {ps2_data, ps2_clock};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      // Two-flop synchroniser for one asynchronous pin
      always_ff @(posedge clock) begin
        if (reset) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= pin_raw[gi];
          sync_reg <= meta_reg;
        end
      end

      assign pin_sync[gi] = sync_reg;
    end
  endgenerate

  logic clk_sync;
  logic data_sync;

  assign clk_sync  = pin_sync[0];
  assign data_sync = pin_sync[1];

  // ---------------------------------------------------------------------------
  // Deglitch filter on the PS/2 clock and falling-edge strobe
  // ---------------------------------------------------------------------------
  logic              filt_clk_reg;
  logic [FLT_W-1:0]  filt_cnt_reg;
  logic              strobe_reg;

  // Accept a level change only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_clk_reg <= 1'b1;
      filt_cnt_reg <= '0;
      strobe_reg   <= 1'b0;
    end else begin
      strobe_reg <= 1'b0;
      if (clk_sync != filt_clk_reg) begin
        if (filt_cnt_reg == FLT_W'(FILTER_LEN - 1)) begin
          filt_clk_reg <= clk_sync;
          filt_cnt_reg <= '0;
          // A toggle away from 1 is the falling edge that clocks a frame bit
          strobe_reg   <= filt_clk_reg;
        end else begin
          filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
      end else begin
        filt_cnt_reg <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [2:0]        bit_cnt_reg;
  logic [7:0]        shift_reg;
  logic              parity_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic              timeout_hit;

  logic              frame_accept;
  logic              frame_parity_bad;
  logic              frame_stop_bad;
  logic              frame_timeout;

  assign timeout_hit = (state_reg != S_IDLE) &&
                       (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: advances on strobe; a stalled partial frame falls back to IDLE
  always_comb begin
    state_next = state_reg;
    if (strobe_reg) begin
      case (state_reg)
        S_IDLE:   if (!data_sync) state_next = S_DATA;
        S_DATA:   if (bit_cnt_reg == 3'd7) state_next = S_PARITY;
        S_PARITY: state_next = S_STOP;
        S_STOP:   state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = S_IDLE;
    end
  end

  // Output logic: frame verdict on the stop-bit strobe, or timeout abandonment
  always_comb begin
    frame_accept     = 1'b0;
    frame_parity_bad = 1'b0;
    frame_stop_bad   = 1'b0;
    frame_timeout    = 1'b0;
    if (strobe_reg && state_reg == S_STOP) begin
      if (!data_sync) begin
        frame_stop_bad = 1'b1;
      end else if (^{shift_reg, parity_reg} != 1'b1) begin
        frame_parity_bad = 1'b1;
      end else begin
        frame_accept = 1'b1;
      end
    end else if (!strobe_reg && timeout_hit) begin
      frame_timeout = 1'b1;
    end
  end

  // Frame datapath: bit counter, LSB-first shifter, parity bit and inactivity timer
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      to_cnt_reg  <= '0;
    end else begin
      if (strobe_reg || state_reg == S_IDLE || timeout_hit) begin
        to_cnt_reg <= '0;
      end else begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
      if (strobe_reg) begin
        case (state_reg)
          S_IDLE: bit_cnt_reg <= '0;
          S_DATA: begin
            shift_reg   <= {data_sync, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
          S_PARITY: parity_reg <= data_sync;
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix merge and error pulses
  // ---------------------------------------------------------------------------
  logic pend_brk_reg;
  logic pend_ext_reg;
  logic push_req;
  logic frame_reject;

  assign frame_reject = frame_parity_bad | frame_stop_bad | frame_timeout;
  assign push_req     = frame_accept && (shift_reg != 8'hF0) && (shift_reg != 8'hE0);

  // Track pending F0/E0 prefixes; any rejected frame forgets them
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_brk_reg <= 1'b0;
      pend_ext_reg <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      parity_error <= frame_parity_bad;
      frame_error  <= frame_stop_bad | frame_timeout;
      if (frame_reject) begin
        pend_brk_reg <= 1'b0;
        pend_ext_reg <= 1'b0;
      end else if (frame_accept) begin
        if (shift_reg == 8'hF0) begin
          pend_brk_reg <= 1'b1;
        end else if (shift_reg == 8'hE0) begin
          pend_ext_reg <= 1'b1;
        end else begin
          pend_brk_reg <= 1'b0;
          pend_ext_reg <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Code FIFO: {ext, brk, byte} entries, head shown combinationally
  // ---------------------------------------------------------------------------
  logic [9:0]          fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_reg;
  logic [FIFO_AW-1:0]  rd_ptr_reg;
  logic [FIFO_AW:0]    count_reg;
  logic                fifo_full;
  logic                do_pop;
  logic                do_push;
  logic [9:0]          head;

  assign fifo_full  = (count_reg == (FIFO_AW + 1)'(FIFO_DEPTH));
  assign code_valid = (count_reg != '0);
  assign do_pop     = code_valid && code_ready;
  assign do_push    = push_req && (!fifo_full || do_pop);
  assign fifo_count = count_reg;

  // Hide stale storage while empty so the outputs read zero
  assign head          = code_valid ? fifo_mem[rd_ptr_reg] : 10'd0;
  assign code_out      = head[7:0];
  assign code_break    = head[8];
  assign code_extended = head[9];

  // Storage write
  always_ff @(posedge clock) begin
    if (do_push) begin
      fifo_mem[wr_ptr_reg] <= {pend_ext_reg, pend_brk_reg, shift_reg};
    end
  end

  // Pointers, occupancy and the dropped-code pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= push_req && fifo_full && !do_pop;
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver: bit-banged PS/2 frames, a scoreboard
// queue of expected FIFO entries checked at each handshake, and pulse counters.
module tb_ps2_scancode_receiver;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int FIFO_DEPTH     = 8;
  localparam int FIFO_AW        = 3;
  localparam int HALF           = 24;
  localparam int GLITCH_HI_AT   = 5;
  localparam int GLITCH_LO_AT   = 13;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               ps2_clock = 1'b1;
  logic               ps2_data = 1'b1;
  logic [7:0]         code_out;
  logic               code_break;
  logic               code_extended;
  logic               code_valid;
  logic               code_ready = 1'b1;
  logic [FIFO_AW:0]   fifo_count;
  logic               parity_error;
  logic               frame_error;
  logic               overflow;

  int checks = 0;
  int errors = 0;

  logic [11:0] sb [$];
  int par_cnt = 0;
  int frm_cnt = 0;
  int ovf_cnt = 0;
  int valid_cycles = 0;
  int long_pulses = 0;
  logic prev_par = 1'b0, prev_frm = 1'b0, prev_ovf = 1'b0;

  int exp_par = 0;
  int exp_frm = 0;
  int exp_ovf = 0;

  ps2_scancode_receiver #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .FIFO_AW       (FIFO_AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ps2_clock    (ps2_clock),
    .ps2_data     (ps2_data),
    .code_out     (code_out),
    .code_break   (code_break),
    .code_extended(code_extended),
    .code_valid   (code_valid),
    .code_ready   (code_ready),
    .fifo_count   (fifo_count),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and pulse monitor, sampled on the falling system clock edge
  always @(negedge clock) begin
    if (!reset) begin
      if (code_valid) valid_cycles++;
      if (code_valid && code_ready) begin
        logic [11:0] exp_e;
        exp_e = (sb.size() > 0) ? sb.pop_front() : 12'hFFF;
        check("sb_entry", {20'd0, 1'b0, code_extended, code_break, code_out}, {20'd0, exp_e});
        $display("pop code=%02h brk=%0b ext=%0b", code_out, code_break, code_extended);
      end
      if (parity_error) par_cnt++;
      if (frame_error)  frm_cnt++;
      if (overflow)     ovf_cnt++;
      if ((parity_error && prev_par) || (frame_error && prev_frm) || (overflow && prev_ovf))
        long_pulses++;
      prev_par = parity_error;
      prev_frm = frame_error;
      prev_ovf = overflow;
    end
  end

  // One PS/2 bit: data set while clock high, then a low phase; optional short glitches
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      repeat (GLITCH_HI_AT) @(negedge clock);
      ps2_clock = 1'b0;
      repeat (FILTER_LEN - 1) @(negedge clock);
      ps2_clock = 1'b1;
      repeat (HALF - GLITCH_HI_AT - (FILTER_LEN - 1)) @(negedge clock);
    end else begin
      repeat (HALF) @(negedge clock);
    end
    ps2_clock = 1'b0;
    if (glitch) begin
      repeat (GLITCH_LO_AT) @(negedge clock);
      ps2_clock = 1'b1;
      repeat (FILTER_LEN - 1) @(negedge clock);
      ps2_clock = 1'b0;
      repeat (HALF - GLITCH_LO_AT - (FILTER_LEN - 1)) @(negedge clock);
    end else begin
      repeat (HALF) @(negedge clock);
    end
    ps2_clock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int glitch_idx, input int n_bits);
    logic [10:0] fr;
    logic par;
    par = ~(^b) ^ bad_par;
    fr  = {~bad_stop, par, b, 1'b0};
    for (int i = 0; i < n_bits; i++) ps2_bit(fr[i], i == glitch_idx);
    ps2_data = 1'b1;
    $display("sent byte=%02h bad_par=%0b bad_stop=%0b glitch=%0d bits=%0d",
             b, bad_par, bad_stop, glitch_idx, n_bits);
  endtask

  task automatic settle();
    repeat (40) @(negedge clock);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, -1, 11);
    settle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_valid", code_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_code", {code_extended, code_break, code_out}, 0);
    check("rst_pulses", {parity_error, frame_error, overflow}, 0);

    // Plain make code
    v0 = valid_cycles;
    sb.push_back({1'b0, 1'b0, 1'b0, 8'h1C});
    good(8'h1C);
    check("make_popped", sb.size(), 0);
    check("make_valid_1cyc", valid_cycles - v0, 1);

    // Break prefix, then extended + break prefixes
    sb.push_back({1'b0, 1'b0, 1'b1, 8'h1C});
    good(8'hF0); good(8'h1C);
    sb.push_back({1'b0, 1'b1, 1'b1, 8'h75});
    good(8'hE0); good(8'hF0); good(8'h75);
    check("prefix_popped", sb.size(), 0);
    check("prefix_count", fifo_count, 0);

    // Parity error after F0 clears the pending break
    good(8'hF0);
    send_frame(8'h1C, 1'b1, 1'b0, -1, 11); settle();
    exp_par++;
    check("parity_pulse", par_cnt, exp_par);
    check("parity_no_entry", fifo_count, 0);
    sb.push_back({1'b0, 1'b0, 1'b0, 8'h32});
    good(8'h32);
    check("after_parity", sb.size(), 0);

    // Bad stop bit
    send_frame(8'h55, 1'b0, 1'b1, -1, 11); settle();
    exp_frm++;
    check("stop_frame_err", frm_cnt, exp_frm);
    check("stop_no_entry", fifo_count, 0);

    // Partial frame then silence: timeout must not fire early, then must fire
    send_frame(8'h3C, 1'b0, 1'b0, -1, 5);
    repeat (TIMEOUT_CYCLES - 100) @(negedge clock);
    check("timeout_not_early", frm_cnt, exp_frm);
    repeat (200) @(negedge clock);
    exp_frm++;
    check("timeout_frame_err", frm_cnt, exp_frm);
    sb.push_back({1'b0, 1'b0, 1'b0, 8'h2A});
    good(8'h2A);
    check("after_timeout", sb.size(), 0);

    // Overflow: consumer stalled, nine codes into an eight-deep FIFO
    code_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] c;
      c = 8'h10 + 8'(i);
      if (i < FIFO_DEPTH) sb.push_back({1'b0, 1'b0, 1'b0, c});
      good(c);
      check("ovf_fill_count", fifo_count, (i < FIFO_DEPTH) ? i + 1 : FIFO_DEPTH);
      check("ovf_head_stable", code_out, 8'h10);
    end
    exp_ovf++;
    check("ovf_pulse", ovf_cnt, exp_ovf);
    check("ovf_valid", code_valid, 1);
    code_ready = 1'b1;
    repeat (20) @(negedge clock);
    check("drain_count", fifo_count, 0);
    check("drain_sb", sb.size(), 0);

    // Clock glitches in both phases of one data bit
    sb.push_back({1'b0, 1'b0, 1'b0, 8'h4B});
    send_frame(8'h4B, 1'b0, 1'b0, 3, 11); settle();
    check("glitch_popped", sb.size(), 0);

    // Reset mid-frame after a break prefix: nothing queued, prefix forgotten
    good(8'hF0);
    send_frame(8'h66, 1'b0, 1'b0, -1, 4);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("midrst_count", fifo_count, 0);
    check("midrst_valid", code_valid, 0);
    sb.push_back({1'b0, 1'b0, 1'b0, 8'h21});
    good(8'h21);
    check("midrst_next", sb.size(), 0);

    check("final_par", par_cnt, exp_par);
    check("final_frm", frm_cnt, exp_frm);
    check("final_ovf", ovf_cnt, exp_ovf);
    check("pulse_width", long_pulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
